pipeline_control_unit: RTL

Central stall/flush sequencer for the 5-stage pipeline. Drives the write enable of the PC register and the fetch/decode (FD) pipeline register. Drives bubble insertion into decode/execute and the enable of the downstream stages. Resolves load-use hazards, taken-branch flushes, instruction- and data-memory wait states, and halt draining in one place, so the pipeline registers stay plain enable/clear storage.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipeline_control_unit_hazard_detect.sv | 33 +++
 rtl/pipeline_control_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_FLUSH_PEND = 2'd1,
    ST_DRAIN      = 2'd2,
    ST_HALTED     = 2'd3
  } pipe_state_e;

  localparam logic [3:0]  OP_LW       = 4'h8;
  localparam logic [3:0]  OP_HLT      = 4'hF;
  // Opcodes up to this value read rt as a source operand.
  localparam logic [3:0]  RT_USER_MAX = 4'h7;
  localparam logic [15:0] NOP         = 16'h0000;

endpackage

// File: rtl/pipeline_control_unit_hazard_detect.sv
// Combinational load-use compare between the load in execute and the
// source registers of the instruction held in the FD register.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [15:0] instr_fd,
  input  logic        ex_mem_read,
  input  logic [3:0]  ex_rd,
  output logic        load_use
);

  logic [3:0] opcode;
  logic [3:0] rs;
  logic [3:0] rt;
  logic       rs_hit;
  logic       rt_hit;
  logic       unused_mid;

  assign opcode = instr_fd[15:12];
  assign rs     = instr_fd[7:4];
  assign rt     = instr_fd[3:0];

  // Bits [11:8] hold the destination, which never creates a read hazard.
  assign unused_mid = ^instr_fd[11:8];

  assign rs_hit = (ex_rd == rs);
  // Only the low opcodes actually read rt; higher ones use that field as an immediate.
  assign rt_hit = (ex_rd == rt) && (opcode <= RT_USER_MAX);

  // r0 is hard-wired to zero, so a load targeting it never needs a stall.
  assign load_use = ex_mem_read && (ex_rd != 4'h0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_control_unit.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_fd,
  input  logic        ex_mem_read,
  input  logic [3:0]  ex_rd,
  input  logic        branch_taken_d,
  input  logic        imem_stall,
  input  logic        dmem_stall,
  output logic        pc_en,
  output logic        fd_enable,
  output logic        fd_flush,
  output logic        de_bubble,
  output logic        xm_enable,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [1:0] RUN        = ST_RUN;
  localparam logic [1:0] FLUSH_PEND = ST_FLUSH_PEND;
  localparam logic [1:0] DRAIN      = ST_DRAIN;
  localparam logic [1:0] HALTED     = ST_HALTED;
  localparam logic [1:0] DRAIN_INIT = 2'(DRAIN_DEPTH - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [1:0] drain_cnt;
  logic [1:0] drain_cnt_nxt;
  logic       load_use;
  logic       is_hlt;
  logic       unused_operands;

  hazard_detect u_hazard_detect (
    .instr_fd    (instr_fd),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  assign is_hlt          = (instr_fd[15:12] == OP_HLT);
  assign unused_operands = ^instr_fd[11:0];

  // NOTE: every output and next-state signal gets a default at the top of the
  // block so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    pc_en         = 1'b1;
    fd_enable     = 1'b1;
    xm_enable     = 1'b1;
    fd_flush      = 1'b0;
    de_bubble     = 1'b0;
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;

    if (!rst) begin
      // Hold the whole pipeline still while reset is asserted.
      pc_en     = 1'b0;
      fd_enable = 1'b0;
      xm_enable = 1'b0;
    end else if (state == HALTED) begin
      pc_en     = 1'b0;
      fd_enable = 1'b0;
      xm_enable = 1'b0;
    end else if (dmem_stall) begin
      pc_en     = 1'b0;
      fd_enable = 1'b0;
      xm_enable = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (load_use) begin
            pc_en     = 1'b0;
            fd_enable = 1'b0;
            de_bubble = 1'b1;
          end else if (branch_taken_d) begin
            fd_flush = 1'b1;
            // Target is loaded now; the flush must persist until fetch delivers.
            if (imem_stall) state_nxt = FLUSH_PEND;
          end else if (imem_stall) begin
            pc_en    = 1'b0;
            fd_flush = 1'b1;
          end else if (is_hlt) begin
            pc_en         = 1'b0;
            fd_enable     = 1'b0;
            de_bubble     = 1'b1;
            state_nxt     = DRAIN;
            drain_cnt_nxt = DRAIN_INIT;
          end
        end
        FLUSH_PEND: begin
          if (imem_stall) begin
            pc_en     = 1'b0;
            fd_enable = 1'b0;
            fd_flush  = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
        DRAIN: begin
          pc_en     = 1'b0;
          fd_enable = 1'b0;
          de_bubble = 1'b1;
          if (drain_cnt == 2'd0) state_nxt = HALTED;
          else                   drain_cnt_nxt = drain_cnt - 2'd1;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  assign halted = (state == HALTED);

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = !pc_en && rst && ((state == RUN) || (state == FLUSH_PEND));
  assign flush_inc = fd_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (stall_inc && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'h0001;
      if (flush_inc && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'h0001;
    end
  end
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule
